// File: rtl/xnor_share_pkg.sv
// Shared state encoding and sizing helper for the shared XNOR compare arbiter.
package xnor_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Requester-id width; a single requester pair still gets a 1-bit id.
  function automatic int IDW(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/xnor_unit.sv
// Shared bitwise-equality datapath: per-bit XNOR and an all-bits-equal flag.
module xnor_unit
  import xnor_share_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  output logic             match
);

  assign z     = ~(x ^ y);
  assign match = &z;

endmodule

// File: rtl/xnor_share_arbiter.sv
// Round-robin arbiter sharing one xnor_unit among NREQ requesters:
// grant in IDLE, compute in EXEC, one-cycle response strobe in RESP.
module xnor_share_arbiter
  import xnor_share_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_z,
  output logic                  rsp_match,
  output logic [IDW(NREQ)-1:0]  rsp_id,
  output logic                  busy
);

  localparam int            IW      = IDW(NREQ);
  localparam logic [IW-1:0] LAST_ID = IW'(NREQ - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    id_q, id_d;
  logic [IW-1:0]    rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             match_q, match_d;

  logic [WIDTH-1:0] unit_z;
  logic             unit_match;
  logic             win_found;
  logic [IW-1:0]    win_id;

  // First valid requester scanning ptr, ptr+1, ... with wrap at NREQ.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] valid,
                                          input logic [IW-1:0]   ptr);
    logic          found;
    logic [IW-1:0] idx;
    logic [IW-1:0] ci;
    int            cand;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      ci = cand[IW-1:0];
      if (!found && valid[ci]) begin
        found = 1'b1;
        idx   = ci;
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    {win_found, win_id} = rr_pick(req_valid, ptr_q);
  end

  xnor_unit #(.WIDTH(WIDTH)) u_xnor (
    .x     (x_q),
    .y     (y_q),
    .z     (unit_z),
    .match (unit_match)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      rsp_id_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      rsp_id_q <= rsp_id_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      match_q  <= match_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    rsp_id_d = rsp_id_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    match_d  = match_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = EXEC;
          id_d    = win_id;
          x_d     = req_x[win_id*WIDTH +: WIDTH];
          y_d     = req_y[win_id*WIDTH +: WIDTH];
        end
      end
      EXEC: begin
        // Response fields update only here so they hold between responses.
        z_d      = unit_z;
        match_d  = unit_match;
        rsp_id_d = id_q;
        state_d  = RESP;
      end
      RESP: begin
        ptr_d   = (id_q == LAST_ID) ? '0 : id_q + IW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (!rst && state_q == IDLE && win_found) req_ready[win_id]   = 1'b1;
    if (!rst && state_q == RESP)              rsp_valid[rsp_id_q] = 1'b1;
  end

  assign busy      = (state_q == EXEC) || (state_q == RESP);
  assign rsp_z     = z_q;
  assign rsp_match = match_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_xnor_share_arbiter.sv
// Scoreboard bench: a 4x8 arbiter under directed and random traffic and a 3x1 arbiter
// under a directed walk, both predicted by a cycle-level round-robin reference model.
module tb_xnor_share_arbiter;

  localparam int NA = 4;
  localparam int WA = 8;
  localparam int NB = 3;
  localparam int WB = 1;

  typedef struct {
    int         id;
    logic [7:0] z;
    bit         m;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;
  bit mon_en      = 1'b0;

  // Instance A: 4 requesters, 8-bit operands
  logic             rst_a;
  logic [NA-1:0]    a_valid, a_ready, a_rsp_valid;
  logic [NA*WA-1:0] a_x, a_y;
  logic [WA-1:0]    a_rsp_z;
  logic             a_rsp_match, a_busy;
  logic [1:0]       a_rsp_id;

  // Instance B: 3 requesters, 1-bit operands
  logic             rst_b;
  logic [NB-1:0]    b_valid, b_ready, b_rsp_valid;
  logic [NB*WB-1:0] b_x, b_y;
  logic [WB-1:0]    b_rsp_z;
  logic             b_rsp_match, b_busy;
  logic [1:0]       b_rsp_id;

  xnor_share_arbiter #(.NREQ(NA), .WIDTH(WA)) dut_a (
    .clk(clk), .rst(rst_a), .req_valid(a_valid), .req_x(a_x), .req_y(a_y),
    .req_ready(a_ready), .rsp_valid(a_rsp_valid), .rsp_z(a_rsp_z),
    .rsp_match(a_rsp_match), .rsp_id(a_rsp_id), .busy(a_busy)
  );

  xnor_share_arbiter #(.NREQ(NB), .WIDTH(WB)) dut_b (
    .clk(clk), .rst(rst_b), .req_valid(b_valid), .req_x(b_x), .req_y(b_y),
    .req_ready(b_ready), .rsp_valid(b_rsp_valid), .rsp_z(b_rsp_z),
    .rsp_match(b_rsp_match), .rsp_id(b_rsp_id), .busy(b_busy)
  );

  // Reference model state: rotation pointer, first cycle a new grant may happen,
  // cycle of the last handshake, and expected responses in order.
  int            a_ptr, a_free, a_hs;
  int            b_ptr, b_free, b_hs;
  logic [NA-1:0] a_gnt_mask;
  logic [NB-1:0] b_gnt_mask;
  exp_t          qa[$];
  exp_t          qb[$];
  exp_t          a_e, b_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  function automatic int rr_winner(input logic [7:0] pend, input int n, input int ptr);
    int idx;
    for (int k = 0; k < n; k++) begin
      idx = (ptr + k) % n;
      if (pend[idx[2:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic a_req(input int i, input logic [WA-1:0] x, input logic [WA-1:0] y);
    a_x[i*WA +: WA]  = x;
    a_y[i*WA +: WA]  = y;
    a_valid[i[1:0]]  = 1'b1;
  endtask

  task automatic b_req(input int i, input logic [WB-1:0] x, input logic [WB-1:0] y);
    b_x[i*WB +: WB]  = x;
    b_y[i*WB +: WB]  = y;
    b_valid[i[1:0]]  = 1'b1;
  endtask

  // One clock cycle on A: update requesters, predict grant, check, advance.
  task automatic a_cycle(input bit do_rst, input int p_new, input int p_drop,
                         output logic [NA-1:0] got_ready);
    logic [NA-1:0] exp_ready;
    logic [WA-1:0] vx, wx, wy;
    bit            exp_busy;
    int            w;
    a_valid = a_valid & ~a_gnt_mask;
    for (int i = 0; i < NA; i++) begin
      if (a_valid[i[1:0]]) begin
        if ($urandom_range(99) < p_drop) a_valid[i[1:0]] = 1'b0;
      end else if ($urandom_range(99) < p_new) begin
        vx = 8'($urandom);
        a_req(i, vx, ($urandom_range(3) == 0) ? vx : 8'($urandom));
      end
    end
    rst_a      = do_rst;
    exp_ready  = '0;
    a_gnt_mask = '0;
    exp_busy   = (cyc > a_hs) && (cyc < a_free);
    if (do_rst) begin
      qa.delete();
      a_ptr  = 0;
      a_free = 0;
      a_hs   = -10;
    end else if (cyc >= a_free) begin
      w = rr_winner(8'(a_valid), NA, a_ptr);
      if (w >= 0) begin
        wx         = a_x[w*WA +: WA];
        wy         = a_y[w*WA +: WA];
        exp_ready  = NA'(1) << w;
        a_gnt_mask = exp_ready;
        qa.push_back('{id: w, z: ~(wx ^ wy), m: (wx == wy), due: cyc + 2});
        a_hs   = cyc;
        a_free = cyc + 3;
        a_ptr  = (w + 1) % NA;
      end
    end
    #1;
    got_ready = a_ready;
    chk("a_req_ready", a_ready, exp_ready);
    chk("a_busy", a_busy, exp_busy);
    @(posedge clk);
    #1;
  endtask

  task automatic b_cycle(input bit do_rst, input int p_new,
                         output logic [NB-1:0] got_ready);
    logic [NB-1:0] exp_ready;
    logic [WB-1:0] wx, wy;
    bit            exp_busy;
    int            w;
    b_valid = b_valid & ~b_gnt_mask;
    for (int i = 0; i < NB; i++) begin
      if (!b_valid[i[1:0]] && $urandom_range(99) < p_new)
        b_req(i, 1'($urandom), 1'($urandom));
    end
    rst_b      = do_rst;
    exp_ready  = '0;
    b_gnt_mask = '0;
    exp_busy   = (cyc > b_hs) && (cyc < b_free);
    if (do_rst) begin
      qb.delete();
      b_ptr  = 0;
      b_free = 0;
      b_hs   = -10;
    end else if (cyc >= b_free) begin
      w = rr_winner(8'(b_valid), NB, b_ptr);
      if (w >= 0) begin
        wx         = b_x[w*WB +: WB];
        wy         = b_y[w*WB +: WB];
        exp_ready  = NB'(1) << w;
        b_gnt_mask = exp_ready;
        qb.push_back('{id: w, z: {7'd0, ~(wx ^ wy)}, m: (wx == wy), due: cyc + 2});
        b_hs   = cyc;
        b_free = cyc + 3;
        b_ptr  = (w + 1) % NB;
      end
    end
    #1;
    got_ready = b_ready;
    chk("b_req_ready", b_ready, exp_ready);
    chk("b_busy", b_busy, exp_busy);
    @(posedge clk);
    #1;
  endtask

  task automatic a_drain();
    logic [NA-1:0] g;
    for (int k = 0; k < 60 && (a_valid != '0 || qa.size() != 0); k++) a_cycle(1'b0, 0, 0, g);
    chk("a_drain_left", 64'(qa.size()), 0);
  endtask

  task automatic b_drain();
    logic [NB-1:0] g;
    for (int k = 0; k < 60 && (b_valid != '0 || qb.size() != 0); k++) b_cycle(1'b0, 0, g);
    chk("b_drain_left", 64'(qb.size()), 0);
  endtask

  // Response monitors: pop the next expected response whenever one is presented or due.
  always @(negedge clk) begin
    if (mon_en && (a_rsp_valid !== '0 || (qa.size() > 0 && qa[0].due <= cyc))) begin
      if (qa.size() == 0) begin
        chk("a_rsp_unexpected", a_rsp_valid, 0);
      end else begin
        a_e = qa.pop_front();
        chk("a_rsp_cycle", cyc, a_e.due);
        chk("a_rsp_valid", a_rsp_valid, NA'(1) << a_e.id);
        chk("a_rsp_id", a_rsp_id, a_e.id);
        chk("a_rsp_z", a_rsp_z, a_e.z);
        chk("a_rsp_match", a_rsp_match, a_e.m);
        $display("A rsp cycle=%0d id=%0d z=%h match=%0b", cyc, a_rsp_id, a_rsp_z, a_rsp_match);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && (b_rsp_valid !== '0 || (qb.size() > 0 && qb[0].due <= cyc))) begin
      if (qb.size() == 0) begin
        chk("b_rsp_unexpected", b_rsp_valid, 0);
      end else begin
        b_e = qb.pop_front();
        chk("b_rsp_cycle", cyc, b_e.due);
        chk("b_rsp_valid", b_rsp_valid, NB'(1) << b_e.id);
        chk("b_rsp_id", b_rsp_id, b_e.id);
        chk("b_rsp_z", b_rsp_z, b_e.z[0]);
        chk("b_rsp_match", b_rsp_match, b_e.m);
        $display("B rsp cycle=%0d id=%0d z=%h match=%0b", cyc, b_rsp_id, b_rsp_z, b_rsp_match);
      end
    end
  end

  initial begin
    logic [NA-1:0] ga;
    logic [NB-1:0] gb;
    rst_a = 1'b1;  rst_b = 1'b1;
    a_valid = '0;  a_x = '0;  a_y = '0;
    b_valid = '0;  b_x = '0;  b_y = '0;
    a_ptr = 0;  a_free = 0;  a_hs = -10;  a_gnt_mask = '0;
    b_ptr = 0;  b_free = 0;  b_hs = -10;  b_gnt_mask = '0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset held with every requester asking
    for (int i = 0; i < NA; i++) a_req(i, 8'($urandom), 8'($urandom));
    repeat (3) a_cycle(1'b1, 0, 0, ga);
    chk("a_reset_rsp_valid", a_rsp_valid, 0);
    chk("a_reset_rsp_z", a_rsp_z, 0);
    chk("a_reset_rsp_match", a_rsp_match, 0);
    chk("a_reset_rsp_id", a_rsp_id, 0);

    // Fairness: all requesters continuously valid from release
    a_cycle(1'b0, 100, 0, ga);
    chk("a_first_grant", ga, 4'b0001);
    repeat (14) a_cycle(1'b0, 100, 0, ga);
    a_drain();

    // Single matching request on requester 2
    a_req(2, 8'hA5, 8'hA5);
    a_drain();
    chk("a_single_z", a_rsp_z, 8'hFF);
    chk("a_single_match", a_rsp_match, 1);
    chk("a_single_id", a_rsp_id, 2);

    // Mismatching request on requester 1
    a_req(1, 8'h0F, 8'h3C);
    a_drain();
    chk("a_mismatch_z", a_rsp_z, 8'hCC);
    chk("a_mismatch_match", a_rsp_match, 0);
    chk("a_mismatch_id", a_rsp_id, 1);

    // Reset during EXEC of requester 3 drops the operation and rewinds the pointer
    a_req(3, 8'h12, 8'h34);
    a_cycle(1'b0, 0, 0, ga);
    chk("a_grant3", ga, 4'b1000);
    a_cycle(1'b1, 0, 0, ga);
    a_req(1, 8'h55, 8'h55);
    a_req(3, 8'h66, 8'h99);
    a_cycle(1'b0, 0, 0, ga);
    chk("a_post_rst_grant", ga, 4'b0010);
    a_drain();

    // Random traffic with occasional withdrawals and resets
    for (int k = 0; k < 1500; k++) a_cycle($urandom_range(299) == 0, 30, 2, ga);
    rst_a = 1'b0;
    a_drain();

    // WIDTH=1, NREQ=3 instance: walk all operand pairs on requester 2
    repeat (2) b_cycle(1'b1, 0, gb);
    chk("b_reset_rsp_z", b_rsp_z, 0);
    for (int v = 0; v < 4; v++) begin
      b_req(2, 1'(v >> 1), 1'(v));
      b_drain();
      chk("b_walk_z", b_rsp_z, (v == 0 || v == 3) ? 1 : 0);
      chk("b_walk_match", b_rsp_match, (v == 0 || v == 3) ? 1 : 0);
    end
    // Pointer wrapped from 2 back to 0, so requester 0 wins over 1 and 2
    b_req(0, 1'b1, 1'b0);
    b_req(1, 1'b0, 1'b0);
    b_req(2, 1'b1, 1'b1);
    b_cycle(1'b0, 0, gb);
    chk("b_wrap_grant", gb, 3'b001);
    b_drain();
    for (int k = 0; k < 300; k++) b_cycle(1'b0, 40, gb);
    b_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/xnor_share_arbiter.md
# xnor_share_arbiter

Round-robin controller that shares one WIDTH-bit XNOR/equality unit among NREQ requesters. Each requester offers an operand pair (x, y) with a valid/ready handshake. The arbiter grants one requester at a time, sequences the shared unit, and returns z = x XNOR y plus a full-match flag to the granted requester. It sits between the client blocks and the single xnor compare datapath, replacing per-client gate copies.

## Interface

Parameters:
- NREQ, 4: number of requesters (2..8).
- WIDTH, 8: operand width in bits (>=1).

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_x  in  NREQ*WIDTH  packed x operands; requester i occupies bits [i*WIDTH +: WIDTH].
- req_y  in  NREQ*WIDTH  packed y operands, same packing.
- req_ready  out  NREQ  one-hot grant/accept, combinational in IDLE only.
- rsp_valid  out  NREQ  one-hot response strobe, 1 cycle.
- rsp_z  out  WIDTH  ~(x ^ y) of the granted pair.
- rsp_match  out  1  1 when x == y, i.e. &rsp_z.
- rsp_id  out  $clog2(NREQ) (min 1)  index of the responding requester.
- busy  out  1  high in EXEC and RESP.

## Operation

- FSM states are IDLE, EXEC and RESP.
- **IDLE**
  - Winner is the first i with req_valid[i]=1, scanning from ptr upward with wrap (ptr, ptr+1, ..., NREQ-1, 0, ...).
  - req_ready[winner]=1 in the same cycle. That cycle is the handshake.
  - On the edge, latch x, y and the winner id, then go to EXEC.
  - If no req_valid bit is set, stay in IDLE. ptr is unchanged.
- **EXEC**
  - The xnor_unit evaluates the latched operands. Register z and match.
  - Go to RESP.
- **RESP**
  - Drive rsp_valid[id]=1, rsp_id=id, rsp_z and rsp_match for exactly one cycle. There is no backpressure.
  - Set ptr = (id+1) mod NREQ, then go to IDLE.
- req_ready is 0 in EXEC and RESP. Requesters keep req_valid and operands stable until they see their ready.
- A requester deasserting req_valid before grant is legal. It is not granted and no state is kept for it.
- rsp_z, rsp_match and rsp_id hold their last values outside RESP. Only rsp_valid qualifies them.
- Width rules:
  - No arithmetic on operands; bitwise only.
  - ptr wraps modulo NREQ. The NREQ=non-power-of-2 wrap must skip unused codes.

## Timing

- Reset values: state=IDLE, ptr=0, req_ready=0 (while rst=1), rsp_valid=0, rsp_z=0, rsp_match=0, rsp_id=0, busy=0.
- Handshake in cycle N gives rsp_valid in cycle N+2. Latency is 2.
- Next grant is possible in cycle N+3, so peak throughput is 1 op per 3 cycles.
- All NREQ requesting continuously gives grant order ptr, ptr+1, ... The worst-case wait for any requester is 3*(NREQ-1) cycles after it becomes eligible.
- A request asserted in the RESP cycle of another requester is eligible in the following IDLE cycle.
- Reset asserted in EXEC or RESP aborts the operation:
  - no rsp_valid is produced;
  - the in-flight request is lost and the requester must re-request;
  - ptr returns to 0.
- Reset has priority over every transition. req_ready is forced to 0 during rst.

## Structure

- Shared package `xnor_share_pkg` holds:
  - the state enum (IDLE=2'd0, EXEC=2'd1, RESP=2'd2);
  - the id-width function `IDW(n) = max(1, clog2(n))`.
- Sub-module `xnor_unit` is purely combinational:
  - inputs x[WIDTH], y[WIDTH];
  - outputs z = ~(x^y) and match = &z.
- The arbiter instantiates xnor_unit once. The round-robin pick is a local function in the arbiter.

## Test plan

- **Reset:** hold rst 3 cycles with all req_valid=1 → req_ready=0, rsp_valid=0, busy=0 throughout. First grant is to requester 0 on the first cycle after rst drops.
- **Single request:** req 2 with x=8'hA5, y=8'hA5 → req_ready=4'b0100 at N, rsp_valid=4'b0100 at N+2, rsp_z=8'hFF, rsp_match=1, rsp_id=2.
- **Mismatch:** req 1 with x=8'h0F, y=8'h3C → rsp_z=8'hCC, rsp_match=0, rsp_id=1.
- **Fairness:** all four requesters valid continuously from reset → grants 0,1,2,3,0 at cycles 0,3,6,9,12 after reset release. No requester is granted twice before the others.
- **Reset mid-op:** grant req 3, assert rst in the EXEC cycle → no rsp_valid ever for that op. After rst the next grant goes to the lowest valid index (ptr=0).
- **WIDTH=1, NREQ=3:** walk (x,y) = 00,01,10,11 on req 2 → rsp_z = 1,0,0,1, and rsp_match equals rsp_z. The ptr wrap 2→0 is verified.
